// File: rtl/pipe_ctrl.sv
// pipe_ctrl -- pipeline hazard controller for the five-stage core.
//
// Drives the stall/refresh controls of the IF/ID, ID/EX, EX/MEM and MEM/WB
// segment registers. Resolves, highest priority first: exception/eret flush,
// data-memory wait, multiply/divide occupancy of EX, and load-use hazards.
// The block owns no datapath state: only a small sequencing FSM (RUN,
// MD_WAIT, FLUSH) and a 6-bit MD occupancy counter.
//
// Optional feature macro: PIPE_CTRL_PERF_EN
//   defined   -> perf_stall_cycles (saturating) and perf_flushes (wrapping)
//                are implemented.
//   undefined -> both counter registers are omitted and the ports read 0.
//   Hazard behaviour is identical either way.

module pipe_ctrl #(
   parameter int DIV_CYCLES  = 33,
   parameter int MULT_CYCLES = 2
) (
   input  logic        clk,
   input  logic        resetn,
   input  logic        id_rs_ren,
   input  logic        id_rt_ren,
   input  logic [4:0]  id_rs,
   input  logic [4:0]  id_rt,
   input  logic        ex_load,
   input  logic        ex_regwen,
   input  logic [4:0]  ex_wreg,
   input  logic        ex_mult,
   input  logic        ex_div,
   input  logic        mem_data_en,
   input  logic        mem_data_ok,
   input  logic        exc_flush,
   output logic        if_id_stall,
   output logic        if_id_refresh,
   output logic        id_ex_stall,
   output logic        id_ex_refresh,
   output logic        ex_mem_stall,
   output logic        ex_mem_refresh,
   output logic        mem_wb_stall,
   output logic        mem_wb_refresh,
   output logic        md_busy,
   output logic        md_done,
   output logic [31:0] perf_stall_cycles,
   output logic [15:0] perf_flushes
);

   // Counter reload values: the entry cycle is the first of N stalled
   // cycles, so the counter starts at N-1 and the release happens at 0.
   localparam logic [5:0] DIV_LOAD  = 6'(DIV_CYCLES - 1);
   localparam logic [5:0] MULT_LOAD = 6'(MULT_CYCLES - 1);

   // A single-cycle multiply needs no extra EX occupancy at all.
   localparam bit MULT_EN = (MULT_CYCLES > 1);

   typedef enum logic [1:0] {
      ST_RUN     = 2'd0,
      ST_MD_WAIT = 2'd1,
      ST_FLUSH   = 2'd2
   } state_t;

   state_t      r_state;
   state_t      w_nextState;
   logic [5:0]  r_cnt;
   logic [5:0]  w_cntNext;

   logic        w_memWait;
   logic        w_mdReq;
   logic        w_mdEntry;
   logic        w_mdHold;
   logic        w_mdRelease;
   logic        w_rsHit;
   logic        w_rtHit;
   logic        w_loadUseHazard;
   logic        w_loadUse;
   logic        w_cntZero;

   // Condition decode shared by the next-state and output logic.
   always_comb begin
      w_memWait       = mem_data_en & ~mem_data_ok;
      w_mdReq         = ex_div | (ex_mult & MULT_EN);
      w_cntZero       = (r_cnt == 6'd0);

      w_rsHit         = id_rs_ren & (id_rs == ex_wreg);
      w_rtHit         = id_rt_ren & (id_rt == ex_wreg);
      w_loadUseHazard = ex_load & ex_regwen & (ex_wreg != 5'd0)
                        & (w_rsHit | w_rtHit);

      // EX is held during a memory wait, so an MD start is deferred.
      w_mdEntry       = (r_state == ST_RUN) & ~exc_flush & ~w_memWait
                        & w_mdReq;
      w_mdHold        = (r_state == ST_MD_WAIT) & ~w_cntZero;
      w_mdRelease     = (r_state == ST_MD_WAIT) & w_cntZero
                        & ~exc_flush & ~w_memWait;
      w_loadUse       = (r_state == ST_RUN) & ~exc_flush & ~w_memWait
                        & ~w_mdReq & w_loadUseHazard;
   end

   // State and MD counter registers; reset abandons any MD in progress.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         r_state <= ST_RUN;
         r_cnt   <= 6'd0;
      end else begin
         r_state <= w_nextState;
         r_cnt   <= w_cntNext;
      end
   end

   // Next-state and counter update; a flush overrides everything and the
   // MD counter keeps running through a memory wait.
   always_comb begin
      w_nextState = r_state;
      w_cntNext   = r_cnt;
      if (exc_flush) begin
         w_nextState = ST_FLUSH;
         w_cntNext   = 6'd0;
      end else begin
         unique case (r_state)
            ST_RUN: begin
               if (!w_memWait && w_mdReq) begin
                  w_nextState = ST_MD_WAIT;
                  w_cntNext   = ex_div ? DIV_LOAD : MULT_LOAD;
               end
            end
            ST_MD_WAIT: begin
               if (!w_cntZero) begin
                  w_cntNext = r_cnt - 6'd1;
               end else if (!w_memWait) begin
                  w_nextState = ST_RUN;
               end
            end
            ST_FLUSH: begin
               w_nextState = ST_RUN;
            end
            default: begin
               w_nextState = ST_RUN;
               w_cntNext   = 6'd0;
            end
         endcase
      end
   end

   // Segment controls in priority order; each branch asserts at most one of
   // stall/refresh per segment.
   always_comb begin
      if_id_stall    = 1'b0;
      if_id_refresh  = 1'b0;
      id_ex_stall    = 1'b0;
      id_ex_refresh  = 1'b0;
      ex_mem_stall   = 1'b0;
      ex_mem_refresh = 1'b0;
      mem_wb_stall   = 1'b0;
      mem_wb_refresh = 1'b0;
      if (exc_flush) begin
         if_id_refresh  = 1'b1;
         id_ex_refresh  = 1'b1;
         ex_mem_refresh = 1'b1;
         mem_wb_refresh = 1'b1;
      end else if (r_state == ST_FLUSH) begin
         if_id_refresh  = 1'b1;
      end else if (w_memWait) begin
         if_id_stall    = 1'b1;
         id_ex_stall    = 1'b1;
         ex_mem_stall   = 1'b1;
         mem_wb_refresh = 1'b1;
      end else if (w_mdEntry || w_mdHold) begin
         if_id_stall    = 1'b1;
         id_ex_stall    = 1'b1;
         ex_mem_refresh = 1'b1;
      end else if (w_loadUse) begin
         if_id_stall    = 1'b1;
         id_ex_refresh  = 1'b1;
      end
   end

   // MD status flags; a flush aborts the MD so neither flag shows.
   always_comb begin
      md_busy = ~exc_flush & (w_mdEntry | w_mdHold);
      md_done = w_mdRelease;
   end

`ifdef PIPE_CTRL_PERF_EN
   logic [31:0] r_perfStall;
   logic [15:0] r_perfFlush;

   // Stall-cycle counter saturates; flush counter wraps naturally.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         r_perfStall <= 32'd0;
         r_perfFlush <= 16'd0;
      end else begin
         if (if_id_stall && (r_perfStall != 32'hFFFF_FFFF)) begin
            r_perfStall <= r_perfStall + 32'd1;
         end
         if (exc_flush) begin
            r_perfFlush <= r_perfFlush + 16'd1;
         end
      end
   end

   assign perf_stall_cycles = r_perfStall;
   assign perf_flushes      = r_perfFlush;
`else
   assign perf_stall_cycles = 32'd0;
   assign perf_flushes      = 16'd0;
`endif

endmodule

// File: doc/pipe_ctrl.md
# pipe_ctrl

Pipeline hazard controller for the five-stage core. It drives the `stall` and `refresh` inputs of the IF/ID, ID/EX, EX/MEM and MEM/WB segment registers. It resolves four conditions:
- load-use hazards,
- multi-cycle multiply/divide occupancy of EX,
- data-memory wait,
- exception/eret flush.

The block sits beside the datapath and owns no datapath state. It holds only a sequencing FSM and an MD occupancy counter.

## Interface
- `DIV_CYCLES`, 33, total EX occupancy of a divide (≥2)
- `MULT_CYCLES`, 2, total EX occupancy of a multiply (≥1)

- `clk`  in  1  clock
- `resetn`  in  1  asynchronous, active-low reset
- `id_rs_ren`, `id_rt_ren`  in  1 each  ID reads rs / rt
- `id_rs`, `id_rt`  in  5 each  ID source register numbers
- `ex_load`, `ex_regwen`  in  1 each  EX instruction is a load / writes a GPR
- `ex_wreg`  in  5  EX destination register
- `ex_mult`, `ex_div`  in  1 each  EX holds a multiply / divide
- `mem_data_en`  in  1  MEM has an outstanding data access
- `mem_data_ok`  in  1  data access completes this cycle
- `exc_flush`  in  1  MEM commits an exception or eret; flush younger stages
- `if_id_stall`, `if_id_refresh`  out  1 each
- `id_ex_stall`, `id_ex_refresh`  out  1 each
- `ex_mem_stall`, `ex_mem_refresh`  out  1 each
- `mem_wb_stall`, `mem_wb_refresh`  out  1 each
- `md_busy`  out  1  EX is occupied by MD (entry cycle plus MD_WAIT while cnt≠0)
- `md_done`  out  1  one-cycle pulse on the MD release cycle
- `perf_stall_cycles`  out  32  cycles with `if_id_stall`=1
- `perf_flushes`  out  16  count of `exc_flush` cycles

## Operation
- **FSM states:** RUN, MD_WAIT, FLUSH.
  - MD counter `cnt` is 6 bits, sized for DIV_CYCLES ≤ 64.
- **Priority, highest first:** flush > mem_wait > md > load_use.
- **flush** (`exc_flush`=1, any state):
  - all four `*_refresh`=1 and all `*_stall`=0.
  - `cnt` is cleared, MD is aborted with no `md_done` pulse.
  - next state is FLUSH.
- **FLUSH** (one cycle): `if_id_refresh`=1 to kill the fetch in flight; then RUN.
- **mem_wait** (`mem_data_en` & !`mem_data_ok`):
  - IF/ID, ID/EX and EX/MEM stall; `mem_wb_refresh`=1 so a bubble enters WB.
  - FSM state does not change; an MD counter in MD_WAIT keeps decrementing.
- **md entry** (RUN, no flush, no mem_wait, `ex_div` or `ex_mult`):
  - applies only for `ex_div`, or for `ex_mult` with MULT_CYCLES>1.
  - load `cnt` ← N−1, where N is DIV_CYCLES for divide and MULT_CYCLES for multiply; `ex_div` wins if both are set.
  - this cycle IF/ID and ID/EX stall, `ex_mem_refresh`=1; next state MD_WAIT.
- **MD_WAIT:**
  - `cnt`≠0: same stall/refresh pattern as entry; `cnt` decrements.
  - `cnt`=0: no MD stall; `md_done`=1; next state RUN. This is the release cycle and the EX instruction advances.
  - total stalled cycles = N exactly.
- **load_use** (RUN, no higher condition):
  - fires when `ex_load` & `ex_regwen` & `ex_wreg`≠0 & ((`id_rs_ren` & `id_rs`==`ex_wreg`) | (`id_rt_ren` & `id_rt`==`ex_wreg`)).
  - response: `if_id_stall`=1 and `id_ex_refresh`=1, a one-bubble insertion.
- Otherwise every output is 0.
- A stall and a refresh are never both asserted on one segment.

## Timing
- All stall/refresh outputs are combinational from the FSM state, `cnt` and the current inputs, so they are valid in the same cycle.
- FSM state, `cnt` and the perf counters update on `posedge clk`.
- **Reset** (async, `resetn`=0): state=RUN, `cnt`=0, perf counters=0.
  - During reset all outputs evaluate to 0 except those driven by the combinational inputs. The segments reset themselves.
- **Reset mid-MD:** the MD is abandoned with no `md_done`.
- **Simultaneous events:**
  - `exc_flush` together with an MD start: the flush wins and no MD entry occurs.
  - mem_wait together with an MD start: entry is deferred until mem_wait clears, because EX is held.
  - `mem_data_ok` arriving on the MD release cycle: both resolve in that cycle.
- **Counter wrap:**
  - `perf_stall_cycles` saturates at 32'hFFFFFFFF.
  - `perf_flushes` wraps modulo 2^16.

## Configuration
- `PIPE_CTRL_PERF_EN` defined: `perf_stall_cycles` and `perf_flushes` are implemented as specified above.
- `PIPE_CTRL_PERF_EN` undefined: both counter registers are omitted and the ports are tied to 0. Hazard behaviour is identical either way.

## Test plan
- **Load-use:** `ex_load`=1, `ex_regwen`=1, `ex_wreg`=5, `id_rs_ren`=1, `id_rs`=5 → exactly one cycle of `if_id_stall`=1 and `id_ex_refresh`=1. The same stimulus with `ex_wreg`=0 → no stall.
- **Divide:** `ex_div` pulse in RUN, DIV_CYCLES=33 → `if_id_stall` and `id_ex_stall` high for 33 cycles, then `md_done`=1 in cycle 34 with stalls low. `perf_stall_cycles`=33 when PERF is enabled.
- **Multiply with MULT_CYCLES=1:** `ex_mult`=1 → no stall, FSM stays RUN.
- **Flush mid-divide:** `exc_flush` at stall cycle 10 → all four refreshes high that cycle, then `if_id_refresh` only in the next cycle, then RUN. No `md_done` pulse; `perf_flushes`=1.
- **Mem wait during MD_WAIT:** `mem_data_en`=1 with `mem_data_ok` low for 4 cycles starting at MD stall cycle 5 → `ex_mem_stall` and `mem_wb_refresh` high for those 4 cycles. `md_done` still occurs 33 cycles after entry.
- **Async reset:** assert `resetn`=0 mid-MD_WAIT with no clock edge → `md_busy`=0 and perf counters=0 immediately.
